// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller and the ALU control block.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OPC_RTYPE   = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;
    localparam logic [5:0] OPC_INVALID = 6'h3F;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_SLTIU = 3'b101;
    localparam logic [2:0] ALUOP_ORI   = 3'b110;
    localparam logic [2:0] ALUOP_LUI   = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } ctrl_t;

    // Where DECODE goes for a given opcode; FETCH marks an unknown opcode.
    function automatic state_t decode_dest(input logic [5:0] op);
        case (op)
            OPC_RTYPE:                           return ST_EXEC_R;
            OPC_ADDI, OPC_SLTIU, OPC_ORI, OPC_LUI: return ST_EXEC_I;
            OPC_LW, OPC_SW:                      return ST_MEM_ADDR;
            OPC_BEQ, OPC_BNE:                    return ST_BRANCH;
            OPC_J:                               return ST_JUMP;
            default:                             return ST_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] exec_i_aluop(input logic [5:0] op);
        case (op)
            OPC_ADDI:  return ALUOP_ADDI;
            OPC_SLTIU: return ALUOP_SLTIU;
            OPC_ORI:   return ALUOP_ORI;
            OPC_LUI:   return ALUOP_LUI;
            default:   return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Combinational control-vector decode for the multi-cycle controller (Moore
// per state, with the documented input qualifiers on IRWrite/PCWrite).
module mc_ctrl_out_dec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;

    // Per-state control values; anything not set stays at zero.
    always_comb begin
        w_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                w_ctrl.memread = 1'b1;
                w_ctrl.irwrite = i_mem_ready;
                w_ctrl.pcwrite = i_mem_ready;
                w_ctrl.alusrcb = SRCB_FOUR;
            end
            ST_DECODE: begin
                w_ctrl.alusrcb = SRCB_IMM_SH2;
                w_ctrl.illegal = (decode_dest(i_op) == ST_FETCH);
            end
            ST_EXEC_R: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_RT;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
                w_ctrl.aluop   = exec_i_aluop(i_op);
            end
            ST_MEM_ADDR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
            end
            ST_MEM_RD: begin
                w_ctrl.memread = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            ST_MEM_WR: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            ST_WB_R: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
            end
            ST_WB_I: begin
                w_ctrl.regwrite = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_RT;
                w_ctrl.aluop   = ALUOP_SUB;
                w_ctrl.pcsrc   = PCSRC_ALUOUT;
                if (i_op == OPC_BEQ) begin
                    w_ctrl.pcwrite = i_zero;
                end else if (i_op == OPC_BNE) begin
                    w_ctrl.pcwrite = ~i_zero;
                end else begin
                    w_ctrl.pcwrite = 1'b0;
                end
            end
            ST_JUMP: begin
                w_ctrl.pcsrc   = PCSRC_JUMP;
                w_ctrl.pcwrite = 1'b1;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS-style main controller: state register, next-state logic,
// and reset gating of the decoded control vector.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               IRWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IorD_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               MemtoReg_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSrc_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               illegal_o,
    output logic [3:0]         state_o
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;
    ctrl_t      w_ctrl;

    // Opcodes that do not fit the 6-bit table are forced to an unknown code.
    assign w_op = (OP_W'(6'(instr_op_i)) == instr_op_i) ? 6'(instr_op_i) : OPC_INVALID;

    mc_ctrl_out_dec u_out_dec (
        .i_state     (r_state),
        .i_op        (w_op),
        .i_zero      (zero_i),
        .i_mem_ready (mem_ready_i),
        .o_ctrl      (w_ctrl)
    );

    // Next-state selection.
    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:    w_next = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE:   w_next = decode_dest(w_op);
            ST_EXEC_R:   w_next = ST_WB_R;
            ST_EXEC_I:   w_next = ST_WB_I;
            ST_MEM_ADDR: begin
                if (w_op == OPC_LW) begin
                    w_next = ST_MEM_RD;
                end else if (w_op == OPC_SW) begin
                    w_next = ST_MEM_WR;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_MEM_RD:   w_next = mem_ready_i ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WR:   w_next = mem_ready_i ? ST_FETCH : ST_MEM_WR;
            ST_WB_R:     w_next = ST_FETCH;
            ST_WB_I:     w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            default:     w_next = ST_FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are forced to zero for as long as reset is held.
    always_comb begin
        if (rst_i) begin
            PCWrite_o  = w_ctrl.pcwrite;
            IRWrite_o  = w_ctrl.irwrite;
            MemRead_o  = w_ctrl.memread;
            MemWrite_o = w_ctrl.memwrite;
            IorD_o     = w_ctrl.iord;
            RegWrite_o = w_ctrl.regwrite;
            RegDst_o   = w_ctrl.regdst;
            MemtoReg_o = w_ctrl.memtoreg;
            ALUSrcA_o  = w_ctrl.alusrca;
            ALUSrcB_o  = w_ctrl.alusrcb;
            PCSrc_o    = w_ctrl.pcsrc;
            ALUOp_o    = ALUOP_W'(w_ctrl.aluop);
            illegal_o  = w_ctrl.illegal;
            state_o    = r_state;
        end else begin
            PCWrite_o  = 1'b0;
            IRWrite_o  = 1'b0;
            MemRead_o  = 1'b0;
            MemWrite_o = 1'b0;
            IorD_o     = 1'b0;
            RegWrite_o = 1'b0;
            RegDst_o   = 1'b0;
            MemtoReg_o = 1'b0;
            ALUSrcA_o  = 1'b0;
            ALUSrcB_o  = 2'b00;
            PCSrc_o    = 2'b00;
            ALUOp_o    = '0;
            illegal_o  = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule
